// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types used by the inverse-round datapath.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;
  localparam int AES_NR      = 10;
  localparam int AES_RND_W   = 4;

  typedef logic [AES_RND_W-1:0] round_t;
endpackage : aes_pkg

// File: rtl/inv_round_reg_if.sv
// Handshake bundle between two inverse-round stages: upstream side (in_*) and downstream side (out_*).
interface inv_round_reg_if #(
  parameter int DATA_W = aes_pkg::AES_BLOCK_W,
  parameter int KEY_W  = aes_pkg::AES_KEY_W,
  parameter int RND_W  = aes_pkg::AES_RND_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_state;
  logic [KEY_W-1:0]  in_key;
  logic [RND_W-1:0]  in_round;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_state;
  logic [KEY_W-1:0]  out_key;
  logic [RND_W-1:0]  out_round;
  logic              out_last;

  modport slave (
    input  in_valid, in_state, in_key, in_round, out_ready,
    output in_ready, out_valid, out_state, out_key, out_round, out_last
  );

  modport master (
    output in_valid, in_state, in_key, in_round, out_ready,
    input  in_ready, out_valid, out_state, out_key, out_round, out_last
  );
endinterface : inv_round_reg_if

// File: rtl/inv_round_reg.sv
// Inter-round pipeline register for AES-128 decryption: main slot plus skid slot,
// fully registered valid/ready handshake, last-round flag and sticky bad-round error.
module inv_round_reg
  import aes_pkg::*;
#(
  parameter int DATA_W    = AES_BLOCK_W,
  parameter int KEY_W     = AES_KEY_W,
  parameter int RND_W     = AES_RND_W,
  parameter int MAX_ROUND = AES_NR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  inv_round_reg_if.slave  bus,
  output logic            err
);
  localparam logic [RND_W-1:0] MAX_ROUND_L = RND_W'(MAX_ROUND);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_state;
  logic [KEY_W-1:0]  r_main_key;
  logic [RND_W-1:0]  r_main_round;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_state;
  logic [KEY_W-1:0]  r_skid_key;
  logic [RND_W-1:0]  r_skid_round;
  logic              r_in_ready;
  logic              r_err;

  logic w_accept;
  logic w_pop;
  logic w_bad_round;
  logic w_skid_valid_nxt;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_pop       = r_main_valid && bus.out_ready;
  assign w_bad_round = bus.in_round > MAX_ROUND_L;

  // in_ready must be registered, so it is loaded from the skid occupancy the edge will produce.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (w_pop && r_skid_valid)
      w_skid_valid_nxt = w_accept;
    else if (!w_pop && r_main_valid && w_accept)
      w_skid_valid_nxt = 1'b1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_state <= '0;
      r_main_key   <= '0;
      r_main_round <= '0;
      r_skid_valid <= 1'b0;
      r_skid_state <= '0;
      r_skid_key   <= '0;
      r_skid_round <= '0;
      r_in_ready   <= 1'b1;
      r_err        <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_accept && w_bad_round)
        r_err <= 1'b1;

      if (w_pop) begin
        if (r_skid_valid) begin
          r_main_state <= r_skid_state;
          r_main_key   <= r_skid_key;
          r_main_round <= r_skid_round;
          if (w_accept) begin
            r_skid_state <= bus.in_state;
            r_skid_key   <= bus.in_key;
            r_skid_round <= bus.in_round;
          end
        end else if (w_accept) begin
          r_main_state <= bus.in_state;
          r_main_key   <= bus.in_key;
          r_main_round <= bus.in_round;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_main_valid) begin
          r_main_valid <= 1'b1;
          r_main_state <= bus.in_state;
          r_main_key   <= bus.in_key;
          r_main_round <= bus.in_round;
        end else begin
          r_skid_state <= bus.in_state;
          r_skid_key   <= bus.in_key;
          r_skid_round <= bus.in_round;
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_state = r_main_state;
  assign bus.out_key   = r_main_key;
  assign bus.out_round = r_main_round;
  assign bus.out_last  = r_main_valid && (r_main_round == '0);
  assign err           = r_err;
endmodule : inv_round_reg

// File: tb/tb_inv_round_reg.sv
// Randomized self-checking bench for inv_round_reg against a two-entry FIFO reference model.
module tb_inv_round_reg;
  import aes_pkg::*;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] state;
    logic [AES_KEY_W-1:0]   key;
    round_t                 round;
  } entry_t;

  logic clk;
  logic rst;
  logic flush;
  logic err;

  inv_round_reg_if bus ();

  inv_round_reg dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .err  (err)
  );

  entry_t q[$];
  bit     m_err;
  int     n_checks;
  int     n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, need done)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input bit v, input int rnd, input bit ordy);
    bus.in_valid  = v;
    bus.in_state  = rand128();
    bus.in_key    = rand128();
    bus.in_round  = round_t'(rnd);
    bus.out_ready = ordy;
  endtask

  task automatic check_outputs();
    bit has = q.size() > 0;
    check("out_valid", bus.out_valid, has);
    check("in_ready", bus.in_ready, q.size() < 2);
    check("err", err, m_err);
    check("out_last", bus.out_last, has && q[0].round == 0);
    if (has) begin
      check("out_state", bus.out_state, q[0].state);
      check("out_key", bus.out_key, q[0].key);
      check("out_round", bus.out_round, q[0].round);
    end
  endtask

  // Apply current inputs across one rising edge, advance the model, check at the falling edge.
  task automatic step(output bit acc);
    bit     do_acc;
    bit     do_pop;
    entry_t e;
    do_acc = bus.in_valid && (q.size() < 2) && !flush;
    do_pop = (q.size() > 0) && bus.out_ready && !flush;
    e = '{bus.in_state, bus.in_key, bus.in_round};
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_acc) begin
        q.push_back(e);
        if (e.round > round_t'(AES_NR)) m_err = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
    acc = do_acc;
  endtask

  initial begin
    bit acc;
    n_checks = 0;
    n_fail   = 0;
    m_err    = 1'b0;
    rst      = 1'b1;
    flush    = 1'b0;
    drive(0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_err", err, 1'b0);
    check("rst_out_state", bus.out_state, 128'h0);
    rst = 1'b0;

    // Single entry with the reference state
    drive(1, 10, 1);
    bus.in_state = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    step(acc);
    check("single_state", bus.out_state, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
    check("single_last", bus.out_last, 1'b0);
    drive(0, 0, 1);
    step(acc);

    // Backpressure: third entry must stall until downstream drains
    drive(1, 9, 0); step(acc);
    drive(1, 8, 0); step(acc);
    drive(1, 7, 0);
    check("bp_full_ready", bus.in_ready, 1'b0);
    step(acc);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    repeat (4) step(acc);

    // Streaming rounds 10..0 at full rate
    for (int r = 10; r >= 0; r--) begin
      drive(1, r, 1);
      step(acc);
    end
    drive(0, 0, 1);
    repeat (2) step(acc);

    // Flush while full, concurrent with an offered entry
    drive(1, 5, 0); step(acc);
    drive(1, 4, 0); step(acc);
    drive(1, 3, 0);
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    drive(0, 0, 1);
    repeat (3) step(acc);

    // Out-of-range round tag: sticky error, entry still delivered
    drive(1, 12, 1); step(acc);
    check("bad_tag_err", err, 1'b1);
    check("bad_tag_round", bus.out_round, 128'd12);
    drive(0, 0, 1);
    repeat (3) step(acc);
    check("bad_tag_sticky", err, 1'b1);
    flush = 1'b1; step(acc); flush = 1'b0;
    check("bad_tag_flush_clr", err, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, $urandom_range(15), $urandom_range(2) != 0);
      flush = ($urandom_range(31) == 0);
      step(acc);
    end
    flush = 1'b0;

    // Asynchronous reset between clock edges with entries held and err set
    drive(1, 13, 0); step(acc);
    drive(1, 2, 0); step(acc);
    drive(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_state", bus.out_state, 128'h0);
    check("arst_err", err, 1'b0);
    check("arst_in_ready", bus.in_ready, 1'b1);
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1);
    repeat (3) step(acc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule : tb_inv_round_reg
